inst_axi_bridge: RTL and testbench

- Converts the IF stage's instruction SRAM-like request port into a read-only AXI4 master on the AR and R channels.
- Sits directly downstream of the fetch unit's inst_sram_* port, between it and the core's AXI crossbar.
- Accepts fetch requests, holds each AR beat stable until it is accepted, and tracks outstanding reads.
- Returns data in order as data_ok/rdata, which the fetch unit consumes.

---
 rtl/inst_axi_bridge.sv | 76 +++++++
 tb/tb_inst_axi_bridge.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/inst_axi_bridge.sv
// inst_axi_bridge: instruction SRAM-like port to read-only AXI4 master (AR/R)
module inst_axi_bridge #(
    parameter int          MAX_OUTST = 2,
    parameter logic [3:0]  ARID_VAL  = 4'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        inst_sram_req,
    input  logic        inst_sram_wr,
    input  logic [1:0]  inst_sram_size,
    input  logic [31:0] inst_sram_addr,
    input  logic [3:0]  inst_sram_wstrb,
    input  logic [31:0] inst_sram_wdata,
    output logic        inst_sram_addr_ok,
    output logic        inst_sram_data_ok,
    output logic [31:0] inst_sram_rdata,
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic [1:0]  arlock,
    output logic [3:0]  arcache,
    output logic [2:0]  arprot,
    output logic        arvalid,
    input  logic        arready,
    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready,
    output logic        bridge_err
);
    localparam int CW = $clog2(MAX_OUTST + 1);
    typedef enum logic {IDLE, SEND} state_t;
    state_t        state;
    logic [CW-1:0] outst_cnt;
    logic [1:0]    size_q;
    logic          can_accept;
    logic          unused;
    assign unused = ^{inst_sram_wstrb, inst_sram_wdata, rid, rresp, rlast};
    // accept needs a free slot and an AR register that is empty or draining now
    assign can_accept        = inst_sram_req & ~inst_sram_wr & (outst_cnt < CW'(MAX_OUTST));
    assign inst_sram_addr_ok = ~reset & can_accept & (state == IDLE | arready);
    assign rready            = ~reset & (outst_cnt != '0);
    assign inst_sram_data_ok = rvalid & rready;
    assign inst_sram_rdata   = rdata;
    assign arvalid           = state == SEND;
    assign arsize            = {1'b0, size_q};
    assign arid              = ARID_VAL;
    assign arlen             = 8'd0;
    assign arburst           = 2'b01;
    assign arlock            = 2'b00;
    assign arcache           = 4'd0;
    assign arprot            = 3'd0;
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            araddr     <= '0;
            size_q     <= '0;
            outst_cnt  <= '0;
            bridge_err <= 1'b0;
        end else begin
            if (inst_sram_addr_ok) begin
                araddr <= inst_sram_addr;
                size_q <= inst_sram_size;
                state  <= SEND;
            end else if (state == SEND && arready) begin
                state <= IDLE;
            end
            outst_cnt <= outst_cnt + CW'(inst_sram_addr_ok) - CW'(inst_sram_data_ok);
            if (inst_sram_req && inst_sram_wr) bridge_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_inst_axi_bridge.sv
// tb_inst_axi_bridge: directed self-checking bench for inst_axi_bridge
module tb_inst_axi_bridge;
    logic        clk = 0;
    logic        reset;
    logic        req, wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic        addr_ok, data_ok;
    logic [31:0] sram_rdata;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst, arlock;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic        arvalid, arready;
    logic [31:0] rdata;
    logic        rvalid, rready, bridge_err;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    inst_axi_bridge #(.MAX_OUTST(2), .ARID_VAL(4'd0)) dut (
        .clk(clk), .reset(reset),
        .inst_sram_req(req), .inst_sram_wr(wr), .inst_sram_size(size),
        .inst_sram_addr(addr), .inst_sram_wstrb(4'hf), .inst_sram_wdata(32'h0),
        .inst_sram_addr_ok(addr_ok), .inst_sram_data_ok(data_ok), .inst_sram_rdata(sram_rdata),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rid(4'd0), .rdata(rdata), .rresp(2'b10), .rlast(1'b1), .rvalid(rvalid), .rready(rready),
        .bridge_err(bridge_err)
    );

    // inputs change at negedge; checks run 1ns later, well away from posedge
    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1; req = 1; wr = 0; size = 2; addr = 32'h1c000000; arready = 1; rvalid = 1; rdata = 32'h5;
        cyc(); #1;
        checks++; if ({addr_ok, data_ok, rready} !== 3'b000) begin failures++; $display("FAIL reset_comb got=%b exp=000", {addr_ok, data_ok, rready}); end
        cyc(); #1;
        checks++; if ({arvalid, araddr, arsize, bridge_err} !== 37'd0) begin failures++; $display("FAIL reset_regs arvalid=%b araddr=%h arsize=%b err=%b exp all 0", arvalid, araddr, arsize, bridge_err); end
    endtask

    task automatic test_single();
        cyc(); reset = 0; req = 1; addr = 32'h1c000000; size = 2; arready = 1; rvalid = 0; #1;
        checks++; if (addr_ok !== 1'b1) begin failures++; $display("FAIL single_addr_ok got=%b exp=1", addr_ok); end
        cyc(); req = 0; #1;
        checks++; if ({arvalid, araddr, arsize, arlen} !== {1'b1, 32'h1c000000, 3'b010, 8'd0}) begin failures++; $display("FAIL single_ar arvalid=%b araddr=%h arsize=%b arlen=%h", arvalid, araddr, arsize, arlen); end
        checks++; if ({arid, arburst, arlock, arcache, arprot} !== {4'd0, 2'b01, 2'b00, 4'd0, 3'd0}) begin failures++; $display("FAIL single_ar_const arid=%h arburst=%b", arid, arburst); end
        cyc(); rvalid = 1; rdata = 32'h02800000; #1;
        checks++; if ({data_ok, sram_rdata, arvalid} !== {1'b1, 32'h02800000, 1'b0}) begin failures++; $display("FAIL single_data got ok=%b rdata=%h arvalid=%b exp 1 02800000 0", data_ok, sram_rdata, arvalid); end
        cyc(); rvalid = 0; #1;
        checks++; if (rready !== 1'b0) begin failures++; $display("FAIL single_drain rready=%b exp=0", rready); end
    endtask

    task automatic test_backpressure();
        cyc(); req = 1; addr = 32'h1c000010; size = 2; arready = 0; #1;
        checks++; if (addr_ok !== 1'b1) begin failures++; $display("FAIL bp_addr_ok got=%b exp=1", addr_ok); end
        for (int i = 1; i <= 4; i++) begin
            cyc(); req = (i < 3); addr = 32'hdeadbeec; #1;
            checks++; if ({arvalid, araddr, addr_ok} !== {1'b1, 32'h1c000010, 1'b0}) begin failures++; $display("FAIL bp_hold c%0d arvalid=%b araddr=%h addr_ok=%b", i, arvalid, araddr, addr_ok); end
        end
        cyc(); arready = 1; #1;
        checks++; if (arvalid !== 1'b1) begin failures++; $display("FAIL bp_handshake arvalid=%b exp=1", arvalid); end
        cyc(); rvalid = 1; rdata = 32'h11111111; #1;
        checks++; if ({arvalid, data_ok, sram_rdata} !== {1'b0, 1'b1, 32'h11111111}) begin failures++; $display("FAIL bp_done arvalid=%b ok=%b rdata=%h", arvalid, data_ok, sram_rdata); end
        cyc(); rvalid = 0; #1;
        checks++; if (rready !== 1'b0) begin failures++; $display("FAIL bp_drain rready=%b exp=0", rready); end
    endtask

    task automatic test_outst_limit();
        cyc(); req = 1; addr = 32'h1c000000; arready = 1; rvalid = 0; #1;
        checks++; if (addr_ok !== 1'b1) begin failures++; $display("FAIL lim_c0 addr_ok=%b exp=1", addr_ok); end
        cyc(); addr = 32'h1c000004; #1;
        checks++; if ({addr_ok, arvalid, araddr} !== {1'b1, 1'b1, 32'h1c000000}) begin failures++; $display("FAIL lim_c1 addr_ok=%b arvalid=%b araddr=%h", addr_ok, arvalid, araddr); end
        cyc(); addr = 32'h1c000008; #1;
        checks++; if ({addr_ok, arvalid, araddr} !== {1'b0, 1'b1, 32'h1c000004}) begin failures++; $display("FAIL lim_c2 addr_ok=%b arvalid=%b araddr=%h", addr_ok, arvalid, araddr); end
        cyc(); rvalid = 1; rdata = 32'haaaa0000; #1;
        checks++; if ({addr_ok, data_ok, arvalid, sram_rdata} !== {1'b0, 1'b1, 1'b0, 32'haaaa0000}) begin failures++; $display("FAIL lim_nobypass addr_ok=%b ok=%b arvalid=%b rdata=%h", addr_ok, data_ok, arvalid, sram_rdata); end
        cyc(); rvalid = 0; #1;
        checks++; if (addr_ok !== 1'b1) begin failures++; $display("FAIL lim_unblock addr_ok=%b exp=1", addr_ok); end
        cyc(); req = 0; rvalid = 1; rdata = 32'hbbbb0000; #1;
        checks++; if ({arvalid, araddr, data_ok, sram_rdata} !== {1'b1, 32'h1c000008, 1'b1, 32'hbbbb0000}) begin failures++; $display("FAIL lim_third arvalid=%b araddr=%h ok=%b rdata=%h", arvalid, araddr, data_ok, sram_rdata); end
        cyc(); rdata = 32'hcccc0000; #1;
        checks++; if ({data_ok, arvalid} !== 2'b10) begin failures++; $display("FAIL lim_last ok=%b arvalid=%b exp 1 0", data_ok, arvalid); end
        cyc(); rvalid = 0; #1;
        checks++; if (rready !== 1'b0) begin failures++; $display("FAIL lim_drain rready=%b exp=0", rready); end
    endtask

    task automatic test_simultaneous();
        cyc(); req = 1; addr = 32'h1c000100; arready = 1; rvalid = 0; #1;
        checks++; if (addr_ok !== 1'b1) begin failures++; $display("FAIL sim_c0 addr_ok=%b exp=1", addr_ok); end
        cyc(); addr = 32'h1c000104; rvalid = 1; rdata = 32'hd0d0d0d0; #1;
        checks++; if ({addr_ok, data_ok, sram_rdata} !== {1'b1, 1'b1, 32'hd0d0d0d0}) begin failures++; $display("FAIL sim_both addr_ok=%b ok=%b rdata=%h", addr_ok, data_ok, sram_rdata); end
        cyc(); req = 0; rvalid = 0; #1;
        checks++; if ({rready, arvalid, araddr} !== {1'b1, 1'b1, 32'h1c000104}) begin failures++; $display("FAIL sim_hold rready=%b arvalid=%b araddr=%h", rready, arvalid, araddr); end
        cyc(); rvalid = 1; rdata = 32'hd1d1d1d1; #1;
        checks++; if ({data_ok, sram_rdata} !== {1'b1, 32'hd1d1d1d1}) begin failures++; $display("FAIL sim_second ok=%b rdata=%h", data_ok, sram_rdata); end
        cyc(); rvalid = 0; #1;
        checks++; if (rready !== 1'b0) begin failures++; $display("FAIL sim_cnt rready=%b exp=0", rready); end
    endtask

    task automatic test_spurious_write();
        cyc(); req = 0; rvalid = 1; rdata = 32'h99; #1;
        checks++; if ({rready, data_ok, bridge_err} !== 3'b000) begin failures++; $display("FAIL spur rready=%b ok=%b err=%b exp 000", rready, data_ok, bridge_err); end
        cyc(); rvalid = 0; req = 1; wr = 1; addr = 32'h1c000400; #1;
        checks++; if (addr_ok !== 1'b0) begin failures++; $display("FAIL wr_addr_ok got=%b exp=0", addr_ok); end
        cyc(); req = 0; wr = 0; #1;
        checks++; if ({bridge_err, arvalid} !== 2'b10) begin failures++; $display("FAIL wr_err err=%b arvalid=%b exp 1 0", bridge_err, arvalid); end
        cyc(); #1;
        checks++; if (bridge_err !== 1'b1) begin failures++; $display("FAIL wr_sticky err=%b exp=1", bridge_err); end
    endtask

    task automatic test_reset_mid();
        cyc(); req = 1; addr = 32'h1c000200; arready = 0; #1;
        checks++; if (addr_ok !== 1'b1) begin failures++; $display("FAIL rm_accept addr_ok=%b exp=1", addr_ok); end
        cyc(); reset = 1; #1;
        checks++; if ({arvalid, addr_ok, rready} !== 3'b100) begin failures++; $display("FAIL rm_inreset arvalid=%b addr_ok=%b rready=%b exp 100", arvalid, addr_ok, rready); end
        cyc(); reset = 0; req = 0; arready = 1; #1;
        checks++; if ({arvalid, rready, addr_ok, bridge_err} !== 4'b0000) begin failures++; $display("FAIL rm_after arvalid=%b rready=%b addr_ok=%b err=%b exp 0000", arvalid, rready, addr_ok, bridge_err); end
        cyc(); req = 1; addr = 32'h1c000300; size = 2; #1;
        checks++; if (addr_ok !== 1'b1) begin failures++; $display("FAIL rm_fetch addr_ok=%b exp=1", addr_ok); end
        cyc(); req = 0; #1;
        checks++; if ({arvalid, araddr} !== {1'b1, 32'h1c000300}) begin failures++; $display("FAIL rm_ar arvalid=%b araddr=%h", arvalid, araddr); end
        cyc(); rvalid = 1; rdata = 32'h12345678; #1;
        checks++; if ({data_ok, sram_rdata} !== {1'b1, 32'h12345678}) begin failures++; $display("FAIL rm_data ok=%b rdata=%h", data_ok, sram_rdata); end
        cyc(); rvalid = 0; #1;
        checks++; if (rready !== 1'b0) begin failures++; $display("FAIL rm_drain rready=%b exp=0", rready); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_outst_limit();
        test_simultaneous();
        test_spurious_write();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
